boe_frame_feeder: RTL
=====================

# boe_frame_feeder

Upstream framing stage for the batch order-statistics engine. It accepts a valid/ready byte stream with an end-of-frame marker and buffers one frame of 1..DEPTH bytes. It then replays the frame to the engine in the engine's serial format, with the element count on the first beat. It holds off the next frame until the engine has finished emitting its sum, min and sorted results.

## Interface
- DEPTH, 6, maximum bytes per frame; legal range 1..7, limited by the 3-bit count.
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; synchronous and active-high.
- in_valid  input  1  upstream byte valid.
- in_ready  output  1  feeder can accept a byte this cycle.
- in_data  input  8  upstream byte.
- in_last  input  1  qualifies in_data as the final byte of the frame.
- data_num  output  3  to engine: frame length N on the first beat, 0 otherwise.
- data_in  output  8  to engine: frame byte.
- busy  output  1  high whenever the feeder is not in COLLECT.

## Operation
- States:
  - COLLECT: filling the buffer.
  - SEND: replaying N bytes.
  - DRAIN: waiting out the engine's result phase.
- Buffer: DEPTH x 8-bit registers plus a write count wcnt (0..DEPTH).
- COLLECT:
  - in_ready = 1. A byte is accepted when in_valid & in_ready; it is written to buf[wcnt] and wcnt increments.
  - Frame close: an accepted byte with in_last = 1, or the DEPTH-th accepted byte regardless of in_last, closes the frame.
  - On close, N latches as the final wcnt (1..DEPTH) and the state goes to SEND.
- SEND lasts exactly N cycles, index k = 0..N-1:
  - k = 0: data_num = N, data_in = buf[0].
  - k = 1..N-1: data_num = 0, data_in = buf[k].
  - After k = N-1, go to DRAIN.
- DRAIN lasts exactly N+2 cycles with data_num = 0 and data_in = 0.
  - These cycles cover the engine's sum beat, min beat and N sorted beats.
  - After DRAIN, go to COLLECT with wcnt = 0.
- in_ready = 0 in SEND and DRAIN. Upstream must hold in_valid/in_data/in_last stable until accepted.
- Outside SEND, data_num = 0 and data_in = 0.
- Bytes are replayed in arrival order; no reordering in this stage.

## Timing
- Reset (rst high at a clock edge):
  - State = COLLECT, wcnt = 0, N = 0, buffer cleared.
  - data_num = 0, data_in = 0, busy = 0.
  - in_ready is forced 0 combinationally while rst is high and rises in the first cycle with rst low.
- data_num, data_in and busy are registered. in_ready is combinational from state and rst.
- Latency: if the closing byte is accepted at edge c, the first SEND beat (data_num = N) is driven in the cycle after edge c, and busy rises in that same cycle.
- Engine spacing:
  - Last SEND beat at cycle t.
  - DRAIN occupies cycles t+1..t+N+2.
  - in_ready returns 1 at cycle t+N+3.
  - The earliest next first beat is t+N+4, assuming a 1-byte frame accepted at t+N+3.
- Total frame occupancy from the close edge to in_ready high: 2N+2 cycles.
- Boundaries:
  - in_valid high while in_ready = 0: no acceptance and no state change.
  - in_last on the DEPTH-th byte: identical to forced close; N = DEPTH.
  - Byte DEPTH+1 of an unterminated stream is not accepted during that frame. It becomes the first byte of the next frame.
  - N = 1: SEND is one beat with data_num = 1; DRAIN is 3 cycles.
- Reset mid-SEND or mid-DRAIN: the partial frame is discarded and the next frame starts clean. The downstream engine is reset from the same rst.

## Test plan
- Bytes 10, 40, 20 with in_last on 20 -> SEND beats (3,10), (0,40), (0,20); then 5 cycles of (0,0); in_ready high on the 6th cycle after the last beat.
- 8 bytes streamed with in_valid held high and no in_last, DEPTH = 6 -> first frame N = 6 carrying bytes 1..6. Bytes 7 and 8 are stalled until COLLECT resumes (14 cycles after the close edge), then start the next frame.
- Single byte 255 with in_last -> one beat (1,255); busy high for exactly 4 cycles (1 SEND + 3 DRAIN).
- in_valid toggled 1,0,1,0 during COLLECT with bytes 5, 6 (last) -> only the valid cycles are accepted; SEND beats (2,5), (0,6).
- rst pulsed for one cycle at SEND beat k = 1 of a 4-byte frame -> the next cycle has data_num = 0, data_in = 0, busy = 0, in_ready = 1. A new frame 7, 9 (last) replays as (2,7), (0,9).
- Back-to-back frames into the engine model: the sum/min/sorted outputs are correct for both frames, with no beat arriving during the engine's result phase.

Source files
------------

// File: rtl/boe_frame_feeder_if.sv
// Byte-stream intake and engine-side beat bus for boe_frame_feeder.
// master is the upstream/engine side, slave is the feeder.
interface boe_frame_feeder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic [2:0] data_num;
  logic [7:0] data_in;
  logic       busy;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, data_num, data_in, busy
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, data_num, data_in, busy
  );
endinterface

// File: rtl/boe_frame_feeder.sv
// Buffers one frame of 1..DEPTH bytes, replays it to the order-statistics engine
// with the length on the first beat, then waits out the engine's result phase.
//
// state   | meaning
// COLLECT | accepting bytes into the buffer, in_ready high
// SEND    | replaying N buffered bytes, one per cycle
// DRAIN   | idle for N+2 cycles while the engine emits sum, min and sorted data
module boe_frame_feeder #(
  parameter int DEPTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  boe_frame_feeder_if.slave  bus
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SEND    = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(DEPTH - 1);

  state_t     state_q, state_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic [2:0] n_q, n_d;
  logic [2:0] k_q, k_d;
  logic [3:0] dcnt_q, dcnt_d;
  logic [7:0] mem_q [DEPTH];

  logic [2:0] num_q, num_d;
  logic [7:0] dat_q, dat_d;
  logic       busy_q, busy_d;

  logic       accept;
  logic       close;
  logic [2:0] rd_idx;
  logic [7:0] rd_byte;

  assign bus.in_ready = (state_q == COLLECT) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign close        = accept && (bus.in_last || (wcnt_q == LAST_IDX));

  assign bus.data_num = num_q;
  assign bus.data_in  = dat_q;
  assign bus.busy     = busy_q;

  // Outputs are registered, so the read port looks one beat ahead of k_q.
  always_comb begin
    rd_idx = 3'd0;
    if (state_q == SEND) begin
      rd_idx = k_q + 3'd1;
    end
  end

  always_comb begin
    rd_byte = 8'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == 3'(i)) begin
        rd_byte = mem_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    n_d     = n_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    num_d   = 3'd0;
    dat_d   = 8'd0;

    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          wcnt_d = wcnt_q + 3'd1;
        end
        if (close) begin
          state_d = SEND;
          n_d     = wcnt_q + 3'd1;
          k_d     = 3'd0;
          num_d   = wcnt_q + 3'd1;
          // A one-byte frame has its only byte still on the input this edge.
          dat_d   = (wcnt_q == 3'd0) ? bus.in_data : mem_q[0];
        end
      end

      SEND: begin
        if (k_q == n_q - 3'd1) begin
          state_d = DRAIN;
          dcnt_d  = {1'b0, n_q} + 4'd1;
        end else begin
          k_d   = k_q + 3'd1;
          dat_d = rd_byte;
        end
      end

      DRAIN: begin
        if (dcnt_q == 4'd0) begin
          state_d = COLLECT;
          wcnt_d  = 3'd0;
        end else begin
          dcnt_d = dcnt_q - 4'd1;
        end
      end

      default: begin
        state_d = COLLECT;
        wcnt_d  = 3'd0;
      end
    endcase

    busy_d = (state_d != COLLECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      wcnt_q  <= 3'd0;
      n_q     <= 3'd0;
      k_q     <= 3'd0;
      dcnt_q  <= 4'd0;
      num_q   <= 3'd0;
      dat_q   <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      n_q     <= n_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
      num_q   <= num_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wcnt_q == 3'(i)) begin
          mem_q[i] <= bus.in_data;
        end
      end
    end
  end

endmodule
